multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle RV32I control FSM; successor to the single-cycle decoder. Sequences FETCH/DECODE/EXEC/MEM/WB
//  over a shared datapath with one unified memory port (ready handshake, wait states, timeout).
//  Flags illegal encodings. Optional RV32M sequencing via an external iterative MDU.
// PARAMETERS
//  MEM_TIMEOUT  16  max wait cycles per memory access before bus error; 0 = timeout disabled
//  ALU_CTRL_W   4   alu_control width
//  IMM_SRC_W    3   imm_src width
// PORTS
//  clk          in   1          clock; all state updates on rising edge
//  rst          in   1          synchronous, active-high reset
//  instr        in   32         instruction register contents (valid from DECODE on)
//  mem_ready    in   1          memory completes current request this cycle
//  branch_taken in   1          branch-unit compare result for current B-type (valid in EXEC)
//  mdu_done     in   1          MDU result valid (ignored without RV32M_EN)
//  mem_req      out  1          memory request
//  mem_we       out  1          write request (stores)
//  mem_sel      out  1          address source: 0=PC, 1=ALUOut
//  ir_write     out  1          latch fetched word into IR and PC into oldPC
//  pc_write     out  1          update PC
//  pc_src       out  1          next PC: 0=ALU result, 1=ALUOut
//  reg_write    out  1          register-file write enable
//  alu_src_a    out  2          00=PC 01=rs1 10=oldPC 11=zero
//  alu_src_b    out  2          00=rs2 01=imm 10=const 4
//  imm_src      out  IMM_SRC_W  000 I, 001 S, 010 B, 011 J, 100 U
//  alu_control  out  ALU_CTRL_W 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU
//  result_src   out  2          00=ALUOut 01=mem data 10=PC (=oldPC+4) 11=MDU result
//  mdu_start    out  1          one-cycle MDU launch pulse
//  retire       out  1          one-cycle pulse on the last cycle of each instruction
//  illegal      out  1          sticky: illegal instruction decoded
//  bus_err      out  1          sticky: memory timeout
// BEHAVIOUR
//  - Reset: while rst=1, all outputs 0; state <= FETCH, wait counter <= 0, sticky flags cleared.
//    Reset mid-access drops mem_req the same cycle; no partial writeback.
//  - Outputs combinational from state + instr; state and wait counter registered.
//  - FETCH: mem_req=1 mem_sel=0; a=PC b=4 ADD. On mem_ready: ir_write=1 pc_write=1 pc_src=0 -> DECODE.
//  - DECODE: a=oldPC b=imm ADD (branch/jump target into ALUOut); imm_src from opcode.
//    Unknown opcode or R-type funct combo -> ERROR (illegal=1); otherwise -> EXEC.
//  - EXEC:
//    R/I-ALU: a=rs1, b=rs2/imm, alu_control from {funct3,funct7[5]} -> WB (result 00).
//      SRLI/SRAI use funct7[5]; SLLI/SRxI with other funct7 bits set are illegal.
//    LOAD/STORE: a=rs1 b=imm ADD -> MEM.
//    BRANCH: a=rs1 b=rs2 SUB; pc_write=branch_taken pc_src=1; retire -> FETCH.
//    JAL: pc_write=1 pc_src=1 reg_write=1 result_src=10; retire -> FETCH.
//    LUI: a=zero b=imm ADD -> WB.
//  - MEM: mem_req=1 mem_sel=1 mem_we=store. Waits for mem_ready.
//    Store: retire -> FETCH. Load: -> WB (result 01).
//  - WB: reg_write=1; retire=1 -> FETCH.
//  - ERROR: all enables 0; holds until rst.
//  - Latency (zero wait states), FETCH to retire inclusive: branch/JAL/store 3/3/4,
//    ALU/LUI 4, load 5. Each memory wait cycle adds 1.
//  - Wait counter: clog2(MEM_TIMEOUT+1) bits; cleared on entering FETCH/MEM; increments each cycle
//    with mem_req && !mem_ready; reaching MEM_TIMEOUT -> ERROR, bus_err=1.
//    If mem_ready arrives in the timeout cycle, mem_ready wins.
// CONFIGURATION
//  RV32M_EN defined:
//    R-type funct7=0000001 -> EXEC asserts mdu_start for exactly one cycle -> MDU_WAIT.
//    MDU_WAIT holds until mdu_done -> WB (result 11). No timeout on MDU.
//  RV32M_EN undefined:
//    funct7=0000001 decodes illegal; mdu_start tied 0; MDU_WAIT state absent.
// STRUCTURE
//  rv_ctrl_pkg: opcode localparams, alu_op_e, imm_src_e, result_src_e, state_e.
//  Sub-module alu_decoder: combinational {opcode,funct3,funct7} -> alu_control + illegal_alu.
// TESTING
//  1 ADD x3,x1,x2, mem_ready always 1 -> states F,D,E,W; reg_write and retire in cycle 4 only; alu_control=0.
//  2 LW with mem_ready delayed 3 cycles in MEM -> mem_req/mem_sel=1 held 4 cycles; retire in cycle 8.
//  3 BEQ, branch_taken=1 then =0 -> pc_write=1 pc_src=1 in EXEC; then pc_write=0; both retire in cycle 3.
//  4 MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> bus_err=1 after 4 wait cycles; ERROR held until rst.
//  5 instr=32'h0000_0000, then opcode 0110011 funct7=0100000 funct3=111 -> illegal=1, no reg_write;
//    rst mid-FETCH wait -> mem_req=0 same cycle, FETCH after.
//  6 RV32M_EN: MUL, mdu_done after 10 cycles -> mdu_start 1 pulse, reg_write with result_src=11;
//    undefined macro -> illegal=1.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control slice: opcodes, ALU ops, mux selects, FSM states.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
        ALU_SLL  = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_SLT = 4'd8, ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'd0, RES_MEM = 2'd1, RES_PC = 2'd2, RES_MDU = 2'd3
    } result_src_e;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_RS1   = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;
    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;

    typedef logic [2:0] state_e;
    localparam state_e ST_FETCH    = 3'd0;
    localparam state_e ST_DECODE   = 3'd1;
    localparam state_e ST_EXEC     = 3'd2;
    localparam state_e ST_MEM      = 3'd3;
    localparam state_e ST_WB       = 3'd4;
    localparam state_e ST_ERROR    = 3'd5;
`ifdef RV32M_EN
    localparam state_e ST_MDU_WAIT = 3'd6;
`endif

    // alt selects SUB/SRA (funct7[5] for R-type, shift-right-arith for I-type)
    function automatic alu_op_e alu_op_from_funct(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Unified memory port between the control FSM (master) and the memory (slave).
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic mem_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_sel, output mem_ready);
endinterface

// File: rtl/alu_decoder.sv
// Combinational {opcode,funct3,funct7} -> ALU operation, illegal R/I-ALU encodings, MDU select.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_op_e    alu_op,
    output logic       illegal_alu,
    output logic       is_mdu
);

    always_comb begin
        alu_op      = ALU_ADD;
        illegal_alu = 1'b0;
        is_mdu      = 1'b0;
        if (opcode == OP_R) begin
            if (funct7 == 7'b0000000) begin
                alu_op = alu_op_from_funct(funct3, 1'b0);
            end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                alu_op = alu_op_from_funct(funct3, 1'b1);
`ifdef RV32M_EN
            end else if (funct7 == 7'b0000001) begin
                is_mdu = 1'b1;
`endif
            end else begin
                illegal_alu = 1'b1;
            end
        end else if (opcode == OP_IMM) begin
            alu_op = alu_op_from_funct(funct3, (funct3 == 3'b101) && funct7[5]);
            // shift immediates only tolerate funct7[5] (and only on right shifts)
            if (funct3 == 3'b001 && funct7 != 7'b0000000)
                illegal_alu = 1'b1;
            if (funct3 == 3'b101 && {funct7[6], funct7[4:0]} != 6'b000000)
                illegal_alu = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM over a shared datapath and unified memory port.
// Define RV32M_EN to sequence MUL/DIV through an external iterative MDU.
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned ALU_CTRL_W  = 4,
    parameter int unsigned IMM_SRC_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             instr,
    input  logic                    branch_taken,
    input  logic                    mdu_done,
    multicycle_control_if.master    mem,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic                    pc_src,
    output logic                    reg_write,
    output logic [1:0]              alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [IMM_SRC_W-1:0]    imm_src,
    output logic [ALU_CTRL_W-1:0]   alu_control,
    output logic [1:0]              result_src,
    output logic                    mdu_start,
    output logic                    retire,
    output logic                    illegal,
    output logic                    bus_err
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_e     state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic       illegal_q, bus_err_q;
    logic       set_illegal, set_bus_err;
    logic       mem_req_c, mem_we_c, mem_sel_c;
    logic       timeout_hit, opcode_ok;
    alu_op_e    alu_op;
    logic       illegal_alu, is_mdu;
    imm_src_e   imm_sel;

    logic [6:0] opcode;
    assign opcode = instr[6:0];

    alu_decoder u_alu_decoder (
        .opcode      (opcode),
        .funct3      (instr[14:12]),
        .funct7      (instr[31:25]),
        .alu_op      (alu_op),
        .illegal_alu (illegal_alu),
        .is_mdu      (is_mdu)
    );

    logic unused_bits;
`ifdef RV32M_EN
    assign unused_bits = ^{instr[24:15], instr[11:7]};
`else
    assign unused_bits = ^{instr[24:15], instr[11:7], mdu_done, is_mdu};
`endif

    assign mem.mem_req = mem_req_c;
    assign mem.mem_we  = mem_we_c;
    assign mem.mem_sel = mem_sel_c;

    // last permitted wait cycle; a same-cycle mem_ready still completes the access
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        opcode_ok = 1'b0;
        imm_sel   = IMM_I;
        case (opcode)
            OP_R, OP_IMM, OP_LOAD: opcode_ok = 1'b1;
            OP_STORE:  begin opcode_ok = 1'b1; imm_sel = IMM_S; end
            OP_BRANCH: begin opcode_ok = 1'b1; imm_sel = IMM_B; end
            OP_JAL:    begin opcode_ok = 1'b1; imm_sel = IMM_J; end
            OP_LUI:    begin opcode_ok = 1'b1; imm_sel = IMM_U; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state)
                wait_cnt <= '0;
            else if (mem_req_c && !mem.mem_ready)
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (set_illegal)
                illegal_q <= 1'b1;
            if (set_bus_err)
                bus_err_q <= 1'b1;
        end
    end

    always_comb begin
        next_state  = state;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_sel_c   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = SRC_A_PC;
        alu_src_b   = SRC_B_RS2;
        imm_src     = '0;
        alu_control = ALU_CTRL_W'(ALU_ADD);
        result_src  = RES_ALUOUT;
        mdu_start   = 1'b0;
        retire      = 1'b0;
        illegal     = 1'b0;
        bus_err     = 1'b0;
        if (!rst) begin
            illegal = illegal_q;
            bus_err = bus_err_q;
            case (state)
                ST_FETCH: begin
                    mem_req_c = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    if (mem.mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        next_state = ST_DECODE;
                    end else if (timeout_hit) begin
                        set_bus_err = 1'b1;
                        next_state  = ST_ERROR;
                    end
                end
                ST_DECODE: begin
                    alu_src_a = SRC_A_OLDPC;
                    alu_src_b = SRC_B_IMM;
                    imm_src   = IMM_SRC_W'(imm_sel);
                    if (!opcode_ok || illegal_alu) begin
                        set_illegal = 1'b1;
                        next_state  = ST_ERROR;
                    end else begin
                        next_state  = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    imm_src = IMM_SRC_W'(imm_sel);
                    case (opcode)
                        OP_R: begin
                            alu_src_a   = SRC_A_RS1;
                            alu_control = ALU_CTRL_W'(alu_op);
                            next_state  = ST_WB;
`ifdef RV32M_EN
                            if (is_mdu) begin
                                mdu_start  = 1'b1;
                                next_state = ST_MDU_WAIT;
                            end
`endif
                        end
                        OP_IMM: begin
                            alu_src_a   = SRC_A_RS1;
                            alu_src_b   = SRC_B_IMM;
                            alu_control = ALU_CTRL_W'(alu_op);
                            next_state  = ST_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src_a  = SRC_A_RS1;
                            alu_src_b  = SRC_B_IMM;
                            next_state = ST_MEM;
                        end
                        OP_BRANCH: begin
                            alu_src_a   = SRC_A_RS1;
                            alu_control = ALU_CTRL_W'(ALU_SUB);
                            pc_write    = branch_taken;
                            pc_src      = 1'b1;
                            retire      = 1'b1;
                            next_state  = ST_FETCH;
                        end
                        OP_JAL: begin
                            pc_write   = 1'b1;
                            pc_src     = 1'b1;
                            reg_write  = 1'b1;
                            result_src = RES_PC;
                            retire     = 1'b1;
                            next_state = ST_FETCH;
                        end
                        OP_LUI: begin
                            alu_src_a  = SRC_A_ZERO;
                            alu_src_b  = SRC_B_IMM;
                            next_state = ST_WB;
                        end
                        default: begin
                            set_illegal = 1'b1;
                            next_state  = ST_ERROR;
                        end
                    endcase
                end
                ST_MEM: begin
                    mem_req_c = 1'b1;
                    mem_sel_c = 1'b1;
                    mem_we_c  = (opcode == OP_STORE);
                    if (mem.mem_ready) begin
                        if (opcode == OP_STORE) begin
                            retire     = 1'b1;
                            next_state = ST_FETCH;
                        end else begin
                            next_state = ST_WB;
                        end
                    end else if (timeout_hit) begin
                        set_bus_err = 1'b1;
                        next_state  = ST_ERROR;
                    end
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                    result_src = (opcode == OP_LOAD) ? RES_MEM : RES_ALUOUT;
`ifdef RV32M_EN
                    if (is_mdu)
                        result_src = RES_MDU;
`endif
                    next_state = ST_FETCH;
                end
`ifdef RV32M_EN
                ST_MDU_WAIT: begin
                    if (mdu_done)
                        next_state = ST_WB;
                end
`endif
                ST_ERROR: ;
                default: next_state = ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MEM_TIMEOUT=4); RV32M_EN selects the MDU expectations.
module tb_multicycle_control;

    logic        clk, rst;
    logic [31:0] instr;
    logic        branch_taken, mdu_done;
    logic        ir_write, pc_write, pc_src, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [2:0]  imm_src;
    logic [3:0]  alu_control;
    logic        mdu_start, retire, illegal, bus_err;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_control_if mem_if ();

    multicycle_control #(.MEM_TIMEOUT(4), .ALU_CTRL_W(4), .IMM_SRC_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .branch_taken (branch_taken),
        .mdu_done     (mdu_done),
        .mem          (mem_if),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .imm_src      (imm_src),
        .alu_control  (alu_control),
        .result_src   (result_src),
        .mdu_start    (mdu_start),
        .retire       (retire),
        .illegal      (illegal),
        .bus_err      (bus_err)
    );

    // {mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, reg_write, retire}
    logic [7:0]  ctl;
    logic [23:0] all_outs;
    assign ctl = {mem_if.mem_req, mem_if.mem_we, mem_if.mem_sel, ir_write, pc_write, pc_src, reg_write, retire};
    assign all_outs = {ctl, mdu_start, illegal, bus_err, alu_src_a, alu_src_b, imm_src, alu_control, result_src};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [7:0] exp);
        #1;
        check(tag, 32'(ctl), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_outs", 32'(all_outs), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr = 32'h0; branch_taken = 1'b0; mdu_done = 1'b0;
        mem_if.mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // ADD x3,x1,x2: F,D,E,W
        do_reset();
        instr = 32'h002081B3; mem_if.mem_ready = 1'b1;
        cyc("add_fetch", 8'h98);
        #1; check("add_dec_src_a", 32'(alu_src_a), 32'd2); check("add_dec_src_b", 32'(alu_src_b), 32'd1);
        cyc("add_dec", 8'h00);
        #1; check("add_exec_alu", 32'(alu_control), 32'd0); check("add_exec_src_a", 32'(alu_src_a), 32'd1);
        cyc("add_exec", 8'h00);
        #1; check("add_wb_res", 32'(result_src), 32'd0);
        cyc("add_wb", 8'h03);
        cyc("add_next_fetch", 8'h98);

        // LW x5,8(x1) with three MEM wait states
        do_reset();
        instr = 32'h0080A283; mem_if.mem_ready = 1'b1;
        cyc("lw_fetch", 8'h98);
        #1; check("lw_dec_imm", 32'(imm_src), 32'd0);
        cyc("lw_dec", 8'h00);
        #1; check("lw_exec_src_b", 32'(alu_src_b), 32'd1);
        cyc("lw_exec", 8'h00);
        mem_if.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 8'hA0);
        mem_if.mem_ready = 1'b1;
        cyc("lw_mem_done", 8'hA0);
        #1; check("lw_wb_res", 32'(result_src), 32'd1); check("lw_no_buserr", 32'(bus_err), 32'd0);
        cyc("lw_wb", 8'h03);

        // BEQ taken then not taken
        do_reset();
        instr = 32'h00208863; branch_taken = 1'b1;
        cyc("beq_fetch", 8'h98);
        #1; check("beq_dec_imm", 32'(imm_src), 32'd2);
        cyc("beq_dec", 8'h00);
        #1; check("beq_exec_alu", 32'(alu_control), 32'd1);
        cyc("beq_taken", 8'h0D);
        branch_taken = 1'b0;
        cyc("beq2_fetch", 8'h98);
        cyc("beq2_dec", 8'h00);
        cyc("beq_not_taken", 8'h05);
        cyc("beq_after", 8'h98);

        // SW x2,4(x1) then JAL x1,0
        do_reset();
        instr = 32'h0020A223;
        cyc("sw_fetch", 8'h98);
        #1; check("sw_dec_imm", 32'(imm_src), 32'd1);
        cyc("sw_dec", 8'h00);
        cyc("sw_exec", 8'h00);
        cyc("sw_mem", 8'hE1);
        instr = 32'h000000EF;
        cyc("jal_fetch", 8'h98);
        #1; check("jal_dec_imm", 32'(imm_src), 32'd3);
        cyc("jal_dec", 8'h00);
        #1; check("jal_exec_res", 32'(result_src), 32'd2);
        cyc("jal_exec", 8'h0F);
        cyc("jal_after", 8'h98);

        // SRAI x1,x1,3 decodes to SRA
        do_reset();
        instr = 32'h4030D093;
        cyc("srai_fetch", 8'h98);
        cyc("srai_dec", 8'h00);
        #1; check("srai_alu", 32'(alu_control), 32'd7);
        cyc("srai_exec", 8'h00);
        cyc("srai_wb", 8'h03);

        // FETCH timeout: four wait cycles, then ERROR held
        do_reset();
        instr = 32'h002081B3; mem_if.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc("tmo_wait", 8'h80);
        #1; check("tmo_bus_err", 32'(bus_err), 32'd1); check("tmo_illegal", 32'(illegal), 32'd0);
        mem_if.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc("tmo_err_hold", 8'h00);
        #1; check("tmo_bus_err_hold", 32'(bus_err), 32'd1);
        do_reset();
        #1; check("tmo_cleared", 32'(bus_err), 32'd0);

        // all-zero word is illegal
        do_reset();
        instr = 32'h00000000; mem_if.mem_ready = 1'b1;
        cyc("zero_fetch", 8'h98);
        cyc("zero_dec", 8'h00);
        #1; check("zero_illegal", 32'(illegal), 32'd1);
        cyc("zero_err", 8'h00);

        // R-type funct7=0100000 funct3=111: illegal, never writes back
        do_reset();
        instr = 32'h4020F1B3;
        cyc("rbad_fetch", 8'h98);
        cyc("rbad_dec", 8'h00);
        for (int i = 0; i < 3; i++) cyc("rbad_err", 8'h00);
        #1; check("rbad_illegal", 32'(illegal), 32'd1);

        // SLLI with funct7 bit set is illegal
        do_reset();
        instr = 32'h40309093;
        cyc("slli_fetch", 8'h98);
        cyc("slli_dec", 8'h00);
        #1; check("slli_illegal", 32'(illegal), 32'd1);

        // reset mid-FETCH wait clears the wait counter; mem_ready on the limit cycle wins
        do_reset();
        instr = 32'h002081B3; mem_if.mem_ready = 1'b0;
        cyc("midrst_wait", 8'h80);
        cyc("midrst_wait", 8'h80);
        do_reset();
        for (int i = 0; i < 3; i++) cyc("post_rst_wait", 8'h80);
        mem_if.mem_ready = 1'b1;
        cyc("ready_at_limit", 8'h98);
        #1; check("ready_wins_bus_err", 32'(bus_err), 32'd0);
        cyc("ready_wins_dec", 8'h00);

        // MUL x3,x1,x2
        do_reset();
        instr = 32'h022081B3;
        cyc("mul_fetch", 8'h98);
`ifdef RV32M_EN
        cyc("mul_dec", 8'h00);
        #1; check("mul_start", 32'(mdu_start), 32'd1);
        cyc("mul_exec", 8'h00);
        for (int i = 0; i < 9; i++) begin
            #1; check("mul_start_once", 32'(mdu_start), 32'd0);
            cyc("mul_wait", 8'h00);
        end
        mdu_done = 1'b1;
        cyc("mul_done", 8'h00);
        mdu_done = 1'b0;
        #1; check("mul_wb_res", 32'(result_src), 32'd3);
        cyc("mul_wb", 8'h03);
`else
        cyc("mul_dec", 8'h00);
        #1; check("mul_illegal", 32'(illegal), 32'd1); check("mul_no_start", 32'(mdu_start), 32'd0);
        cyc("mul_err", 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
